// File: rtl/task_4_out.sv
// task_4_out: output stage of task 4.
// Buffers one frame of NUM_WORDS words from the input stage, replays it as a
// ready/valid stream with a last-word marker, then pulses o_output_last so
// the input stage can fetch the next frame.
// Optional build macro TASK_4_OUT_CHECKSUM_EN appends an XOR checksum beat.
// Handshake: a beat transfers on a rising edge where o_tdata_valid && i_tready;
// while o_tdata_valid && !i_tready, o_tdata/o_tdata_valid/o_tdata_last hold.
// o_state exposes the FSM state for debug and checkers.
`timescale 1ns/1ps
module task_4_out #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_WORDS  = 243,
   parameter int DEPTH      = 256
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_enb,
   input  logic                  i_tready,
   output logic [DATA_WIDTH-1:0] o_tdata,
   output logic                  o_tdata_valid,
   output logic                  o_tdata_last,
   output logic                  o_output_last,
   output logic                  o_overflow,
   output logic [1:0]            o_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
`ifdef TASK_4_OUT_CHECKSUM_EN
   localparam int BEATS = NUM_WORDS + 1;
`else
   localparam int BEATS = NUM_WORDS;
`endif
   localparam logic [CW-1:0] FRAME_WORDS = CW'(NUM_WORDS);
   localparam logic [CW-1:0] LAST_IDX    = CW'(BEATS - 1);
   localparam logic [CW-1:0] ONE         = CW'(1);

   typedef enum logic [1:0] {
      s_COLLECT = 2'd0,
      s_SEND    = 2'd1,
      s_DONE    = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [CW-1:0]         wr_cnt;
   logic [CW-1:0]         rd_cnt;
   logic [CW-1:0]         rd_sel;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wr_en;
   logic                  hs;
   logic                  first_load;
`ifdef TASK_4_OUT_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum;
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= s_COLLECT;
      else          state <= state_next;
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      hs         = 1'b0;
      first_load = 1'b0;
      case (state)
         s_COLLECT: begin
            if (i_enb) begin
               wr_en = 1'b1;
               // Full-width compare: wr_cnt+1 cannot wrap before reaching NUM_WORDS.
               if (wr_cnt + ONE == FRAME_WORDS) state_next = s_SEND;
            end
         end
         s_SEND: begin
            hs         = o_tdata_valid && i_tready;
            first_load = !o_tdata_valid;
            if (hs && rd_cnt == LAST_IDX) state_next = s_DONE;
         end
         s_DONE:  state_next = s_COLLECT;
         default: state_next = s_COLLECT;
      endcase
   end

   // Select the word to present next: word 0 on entry, rd_cnt+1 after a handshake.
   always_comb begin
      rd_sel  = first_load ? rd_cnt : rd_cnt + ONE;
      rd_word = mem[rd_sel[AW-1:0]];
`ifdef TASK_4_OUT_CHECKSUM_EN
      if (rd_sel == FRAME_WORDS) rd_word = csum;
`endif
   end

   // Frame buffer write port; contents need no reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_cnt[AW-1:0]] <= i_data;
   end

   // Counters and the registered output beat.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         o_tdata       <= '0;
         o_tdata_valid <= 1'b0;
         o_tdata_last  <= 1'b0;
      end else begin
         if (wr_en) wr_cnt <= wr_cnt + ONE;
         if (state == s_SEND) begin
            if (first_load) begin
               o_tdata       <= rd_word;
               o_tdata_valid <= 1'b1;
               o_tdata_last  <= (rd_sel == LAST_IDX);
            end else if (hs) begin
               if (rd_cnt == LAST_IDX) begin
                  o_tdata_valid <= 1'b0;
                  o_tdata_last  <= 1'b0;
                  wr_cnt        <= '0;
                  rd_cnt        <= '0;
               end else begin
                  rd_cnt       <= rd_sel;
                  o_tdata      <= rd_word;
                  o_tdata_last <= (rd_sel == LAST_IDX);
               end
            end
         end
      end
   end

   // Sticky flag: a word offered while not collecting is discarded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                         o_overflow <= 1'b0;
      else if (i_enb && state != s_COLLECT) o_overflow <= 1'b1;
   end

`ifdef TASK_4_OUT_CHECKSUM_EN
   // Running XOR of collected words, cleared once the frame is delivered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)              csum <= '0;
      else if (state == s_DONE)  csum <= '0;
      else if (wr_en)            csum <= csum ^ i_data;
   end
`endif

   assign o_output_last = (state == s_DONE);
   assign o_state       = state;

endmodule

// File: tb/tb_task_4_out.sv
// Bench for task_4_out: default frame instance plus one-word and four-word
// instances; expected beats come from the words the bench itself sent.
`timescale 1ns/1ps
module tb_task_4_out;

   localparam int W = 8;
   localparam int N = 243;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // main instance (NUM_WORDS = 243)
   logic [W-1:0] d_data = '0;
   logic         d_enb = 1'b0, d_tready = 1'b0;
   logic [W-1:0] d_tdata;
   logic         d_valid, d_last, d_olast, d_ovf;
   logic [1:0]   d_state;
   // one-word instance
   logic [W-1:0] s_data = '0;
   logic         s_enb = 1'b0, s_tready = 1'b0;
   logic [W-1:0] s_tdata;
   logic         s_valid, s_last, s_olast, s_ovf;
   logic [1:0]   s_state;
   // four-word instance
   logic [W-1:0] q_data = '0;
   logic         q_enb = 1'b0, q_tready = 1'b0;
   logic [W-1:0] q_tdata;
   logic         q_valid, q_last, q_olast, q_ovf;
   logic [1:0]   q_state;

   task_4_out #(.DATA_WIDTH(W), .NUM_WORDS(N), .DEPTH(256)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(d_data), .i_enb(d_enb), .i_tready(d_tready),
      .o_tdata(d_tdata), .o_tdata_valid(d_valid), .o_tdata_last(d_last),
      .o_output_last(d_olast), .o_overflow(d_ovf), .o_state(d_state));

   task_4_out #(.DATA_WIDTH(W), .NUM_WORDS(1), .DEPTH(1 << 1)) u_one (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(s_data), .i_enb(s_enb), .i_tready(s_tready),
      .o_tdata(s_tdata), .o_tdata_valid(s_valid), .o_tdata_last(s_last),
      .o_output_last(s_olast), .o_overflow(s_ovf), .o_state(s_state));

   task_4_out #(.DATA_WIDTH(W), .NUM_WORDS(4), .DEPTH(4)) u_quad (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(q_data), .i_enb(q_enb), .i_tready(q_tready),
      .o_tdata(q_tdata), .o_tdata_valid(q_valid), .o_tdata_last(q_last),
      .o_output_last(q_olast), .o_overflow(q_ovf), .o_state(q_state));

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0] sent_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic         got_last_q[$];
   int po_cnt, done_delay, stall_bad, gap_cnt, first_valid;
   bit timed_out;

   // ---------------- driver tasks ----------------
   task automatic send_frame(input int n, input logic [W-1:0] mask);
      sent_q.delete();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         d_enb  = 1'b1;
         d_data = 8'(i) ^ mask;
         sent_q.push_back(d_data);
      end
      @(negedge clk);
      d_enb = 1'b0;
   endtask

   // Expected stream: the sent words, plus their XOR when the checksum is built.
   task automatic build_exp();
      logic [W-1:0] x;
      x = '0;
      exp_q.delete();
      foreach (sent_q[i]) begin
         exp_q.push_back(sent_q[i]);
         x = x ^ sent_q[i];
      end
`ifdef TASK_4_OUT_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   // Drives i_tready and records accepted beats and timing observations.
   task automatic collect_beats(input int bp_mode, input int abort_after, input int max_cycles);
      int last_hs;
      bit prev_stall, started;
      logic [W-1:0] held_d;
      logic held_l;
      last_hs = -1; prev_stall = 0; started = 0; held_d = '0; held_l = 1'b0;
      got_q.delete(); got_last_q.delete();
      po_cnt = 0; done_delay = -1; stall_bad = 0; gap_cnt = 0; first_valid = -1;
      timed_out = 1;
      for (int cyc = 0; cyc < max_cycles; cyc++) begin
         @(negedge clk);
         if (d_olast) begin
            po_cnt++;
            if (last_hs >= 0) done_delay = cyc - last_hs;
         end
         if (prev_stall && (d_valid !== 1'b1 || d_tdata !== held_d || d_last !== held_l))
            stall_bad++;
         if (last_hs >= 0 && cyc >= last_hs + 2) begin
            timed_out = 0;
            break;
         end
         if (started && last_hs < 0 && !d_valid) gap_cnt++;
         if (d_valid && first_valid < 0) first_valid = cyc;
         if (d_valid) started = 1;
         d_tready   = (bp_mode == 0) ? 1'b1 : (cyc % 3 == 0);
         prev_stall = d_valid && !d_tready;
         held_d     = d_tdata;
         held_l     = d_last;
         if (d_valid && d_tready) begin
            got_q.push_back(d_tdata);
            got_last_q.push_back(d_last);
            if (d_last) last_hs = cyc;
            if (abort_after > 0 && got_q.size() == abort_after) begin
               timed_out = 0;
               break;
            end
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({d_valid, d_last, d_olast, d_ovf} !== 4'b0000 || d_tdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b last=%b olast=%b ovf=%b data=%h, want all 0",
                  d_valid, d_last, d_olast, d_ovf, d_tdata);
      end
      checks++;
      if (d_state !== 2'd0 || s_state !== 2'd0 || q_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d/%0d/%0d, want 0/0/0", d_state, s_state, q_state);
      end
      checks++;
      if ({s_valid, s_olast, s_ovf, q_valid, q_olast, q_ovf} !== 6'b0) begin
         errors++;
         $display("FAIL reset_small: got s=%b%b%b q=%b%b%b, want 000 000",
                  s_valid, s_olast, s_ovf, q_valid, q_olast, q_ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_frame();
      int bad, nlast;
      send_frame(N, 8'h00);
      build_exp();
      checks++;
      if (d_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: valid=%b one cycle after last write, want 0", d_valid);
      end
      collect_beats(0, 0, 300);
      checks++;
      if (first_valid !== 0) begin
         errors++;
         $display("FAIL latency_first: first valid at cycle %0d, want 0", first_valid);
      end
      checks++;
      if (timed_out || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL full_count: timeout=%0d beats=%0d, want %0d", timed_out, got_q.size(), exp_q.size());
      end else begin
         bad = 0; nlast = 0;
         foreach (exp_q[i]) begin
            if (got_q[i] !== exp_q[i]) bad++;
            if (got_last_q[i]) nlast++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL full_data: %0d beats differ, want 0", bad);
         end
         checks++;
         if (nlast != 1 || got_last_q[got_last_q.size()-1] !== 1'b1) begin
            errors++;
            $display("FAIL full_last: %0d last flags, final=%b, want 1 on final beat",
                     nlast, got_last_q[got_last_q.size()-1]);
         end
      end
      checks++;
      if (gap_cnt != 0) begin
         errors++;
         $display("FAIL full_gaps: %0d bubble cycles, want 0", gap_cnt);
      end
      checks++;
      if (po_cnt != 1 || done_delay != 1) begin
         errors++;
         $display("FAIL full_done: pulses=%0d delay=%0d, want 1 and 1", po_cnt, done_delay);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      send_frame(N, 8'h3C);
      build_exp();
      collect_beats(1, 0, 900);
      checks++;
      if (timed_out || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_count: timeout=%0d beats=%0d, want %0d", timed_out, got_q.size(), exp_q.size());
      end else begin
         bad = 0;
         foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL bp_data: %0d beats differ, want 0", bad);
         end
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL bp_stable: %0d stall cycles changed output, want 0", stall_bad);
      end
      checks++;
      if (po_cnt != 1 || done_delay != 1) begin
         errors++;
         $display("FAIL bp_done: pulses=%0d delay=%0d, want 1 and 1", po_cnt, done_delay);
      end
   endtask

   task automatic test_overflow();
      int bad;
      checks++;
      if (d_ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_idle: got %b, want 0", d_ovf);
      end
      send_frame(N, 8'h00);
      build_exp();
      fork
         collect_beats(0, 0, 300);
         begin
            repeat (20) @(negedge clk);
            d_enb  = 1'b1;
            d_data = 8'hAA;
            @(negedge clk);
            d_enb  = 1'b0;
         end
      join
      bad = 0;
      if (got_q.size() == exp_q.size()) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      checks++;
      if (timed_out || got_q.size() != exp_q.size() || bad != 0) begin
         errors++;
         $display("FAIL ovf_frame: beats=%0d differ=%0d, want %0d and 0", got_q.size(), bad, exp_q.size());
      end
      checks++;
      if (d_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got %b, want 1", d_ovf);
      end
      send_frame(N, 8'h11);
      build_exp();
      collect_beats(0, 0, 300);
      bad = 0;
      if (got_q.size() == exp_q.size()) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      checks++;
      if (timed_out || got_q.size() != exp_q.size() || bad != 0) begin
         errors++;
         $display("FAIL ovf_next_frame: beats=%0d differ=%0d, want %0d and 0", got_q.size(), bad, exp_q.size());
      end
      checks++;
      if (d_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got %b, want 1", d_ovf);
      end
   endtask

   task automatic test_reset_mid_send();
      int bad, olast_seen;
      send_frame(N, 8'h00);
      collect_beats(0, 101, 300);
      checks++;
      if (got_q.size() != 101 || po_cnt != 0) begin
         errors++;
         $display("FAIL mid_partial: beats=%0d pulses=%0d, want 101 and 0", got_q.size(), po_cnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({d_valid, d_last, d_olast, d_ovf} !== 4'b0000 || d_tdata !== 8'h00 || d_state !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset: got valid=%b last=%b olast=%b ovf=%b data=%h state=%0d, want all 0",
                  d_valid, d_last, d_olast, d_ovf, d_tdata, d_state);
      end
      olast_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (d_olast) olast_seen++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (d_olast) olast_seen++;
      checks++;
      if (olast_seen != 0) begin
         errors++;
         $display("FAIL mid_no_done: output_last seen %0d times, want 0", olast_seen);
      end
      send_frame(N, 8'h5A);
      build_exp();
      collect_beats(0, 0, 300);
      bad = 0;
      if (got_q.size() == exp_q.size()) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      checks++;
      if (timed_out || got_q.size() != exp_q.size() || bad != 0 || po_cnt != 1) begin
         errors++;
         $display("FAIL mid_new_frame: beats=%0d differ=%0d pulses=%0d, want %0d, 0, 1",
                  got_q.size(), bad, po_cnt, exp_q.size());
      end
   endtask

   task automatic test_one_word();
      logic [W-1:0] got_d[$];
      logic         got_l[$];
      logic [W-1:0] want_d[$];
      logic         want_l[$];
      int last_hs, olast_cyc, pulses, bad;
      last_hs = -1; olast_cyc = -1; pulses = 0; bad = 0;
      want_d.push_back(8'h5C);
`ifdef TASK_4_OUT_CHECKSUM_EN
      want_l.push_back(1'b0);
      want_d.push_back(8'h5C);
`endif
      want_l.push_back(1'b1);
      @(negedge clk);
      s_enb = 1'b1; s_data = 8'h5C;
      @(negedge clk);
      s_enb = 1'b0; s_tready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (s_olast) begin pulses++; olast_cyc = cyc; end
         if (s_valid && s_tready) begin
            got_d.push_back(s_tdata);
            got_l.push_back(s_last);
            if (s_last) last_hs = cyc;
         end
      end
      if (got_d.size() == want_d.size())
         foreach (want_d[i]) if (got_d[i] !== want_d[i] || got_l[i] !== want_l[i]) bad++;
      checks++;
      if (got_d.size() != want_d.size() || bad != 0) begin
         errors++;
         $display("FAIL one_word_beats: beats=%0d differ=%0d, want %0d and 0", got_d.size(), bad, want_d.size());
      end
      checks++;
      if (pulses != 1 || last_hs < 0 || olast_cyc != last_hs + 1) begin
         errors++;
         $display("FAIL one_word_done: pulses=%0d at %0d after last hs %0d, want 1 at hs+1",
                  pulses, olast_cyc, last_hs);
      end
   endtask

   task automatic test_four_words();
      logic [W-1:0] words[4];
      logic [W-1:0] got_d[$];
      logic         got_l[$];
      logic [W-1:0] want_d[$];
      int pulses, bad, nlast;
      pulses = 0; bad = 0; nlast = 0;
      words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h04; words[3] = 8'h08;
      foreach (words[i]) want_d.push_back(words[i]);
`ifdef TASK_4_OUT_CHECKSUM_EN
      want_d.push_back(8'h0F);
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         q_enb = 1'b1; q_data = words[i];
      end
      @(negedge clk);
      q_enb = 1'b0; q_tready = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(negedge clk);
         if (q_olast) pulses++;
         if (q_valid && q_tready) begin
            got_d.push_back(q_tdata);
            got_l.push_back(q_last);
         end
      end
      if (got_d.size() == want_d.size()) begin
         foreach (want_d[i]) begin
            if (got_d[i] !== want_d[i]) bad++;
            if (got_l[i]) nlast++;
         end
      end
      checks++;
      if (got_d.size() != want_d.size() || bad != 0) begin
         errors++;
         $display("FAIL quad_beats: beats=%0d differ=%0d, want %0d and 0", got_d.size(), bad, want_d.size());
      end
      checks++;
      if (got_l.size() == 0 || nlast != 1 || got_l[got_l.size()-1] !== 1'b1 || pulses != 1) begin
         errors++;
         $display("FAIL quad_last: last flags=%0d pulses=%0d, want 1 on final beat and 1 pulse", nlast, pulses);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_overflow();
      test_reset_mid_send();
      test_one_word();
      test_four_words();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
